// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (I) and data load/store (D) share one memory port.
// Latency: accept at n, mem_en at n+1, mem_rdata sampled at n+1+MEM_LAT, rsp_valid at n+2+MEM_LAT.
// Backpressure: one transaction in flight; ready is only offered in IDLE, to the selected requester.
// Ports: clk/resetn (sync, active-low); i_req_*/i_rsp_* fetch port; d_req_*/d_rsp_* data port;
//        mem_* single-cycle-strobe memory port with MEM_LAT-cycle read latency; busy = not IDLE.
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [31:0]       i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_addr,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_wdata,
  input  logic [3:0]        d_req_wstrb,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t              state, state_nxt;
  logic [2:0]          cnt;
  logic                last_d;     // 1: last grant went to D
  logic                owner_d;
  logic                we_q;
  logic [3:0]          wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         i_data_q;
  logic [31:0]         d_data_q;

  logic                d_sel, i_sel, accept, wait_done;

  // Only the word-address bits are used; the rest of each byte address is dropped on purpose.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr, d_req_addr};

  // On a conflict, favour whoever did not win last time.
  assign d_sel     = d_req_valid && (!i_req_valid || !last_d);
  assign i_sel     = i_req_valid && !d_sel;
  assign accept    = (state == IDLE) && (i_sel || d_sel);
  assign wait_done = (state == WAIT) && (cnt == LAST_CNT);

  always_comb begin
    state_nxt   = state;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 4'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        i_req_ready = i_sel;
        d_req_ready = d_sel;
        if (i_sel || d_sel) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q ? wstrb_q : 4'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_done) state_nxt = RESP;
      end
      RESP: begin
        i_rsp_valid = !owner_d;
        d_rsp_valid = owner_d;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset is synchronous, so the state can still be non-IDLE while resetn is low;
    // mask every strobe so nothing (including a pending write) escapes in that cycle.
    if (!resetn) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 4'b0;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      busy        = 1'b0;
    end
  end

  assign mem_addr   = resetn ? addr_q   : '0;
  assign mem_wdata  = resetn ? wdata_q  : '0;
  assign i_rsp_data = resetn ? i_data_q : '0;
  assign d_rsp_data = resetn ? d_data_q : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      last_d   <= 1'b0;
      owner_d  <= 1'b0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      i_data_q <= 32'h0;
      d_data_q <= 32'h0;
    end else begin
      state <= state_nxt;

      if (state == ACCESS)
        cnt <= 3'd0;
      else if ((state == WAIT) && !wait_done)
        cnt <= cnt + 3'd1;

      // Request fields are snapshotted here so later input changes cannot disturb the access.
      if (accept) begin
        owner_d <= d_sel;
        last_d  <= d_sel;
        if (d_sel) begin
          addr_q  <= d_req_addr[ADDR_W+1:2];
          wdata_q <= d_req_wdata;
          we_q    <= d_req_we;
          wstrb_q <= d_req_wstrb;
        end else begin
          addr_q  <= i_req_addr[ADDR_W+1:2];
          wdata_q <= 32'h0;
          we_q    <= 1'b0;
          wstrb_q <= 4'b0;
        end
      end

      // Response data lands on the edge into RESP and is held until the owner's next response.
      if (wait_done) begin
        if (owner_d)
          d_data_q <= we_q ? 32'h0 : mem_rdata;
        else
          i_data_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        d_valid;
  logic        d4_valid;
  logic        i4_valid;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  // MEM_LAT=1 instance (a_*) and MEM_LAT=4 instance (b_*)
  logic        a_i_ready, a_i_rsp_valid, a_d_ready, a_d_rsp_valid, a_mem_en, a_busy;
  logic [31:0] a_i_rsp_data, a_d_rsp_data, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_we;
  logic [11:0] a_mem_addr;
  logic        b_i_ready, b_i_rsp_valid, b_d_ready, b_d_rsp_valid, b_mem_en, b_busy;
  logic [31:0] b_i_rsp_data, b_d_rsp_data, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_we;
  logic [11:0] b_mem_addr;

  // Memory models: read data is only valid exactly MEM_LAT cycles after mem_en.
  logic [31:0] rd1, rd4;
  logic [3:0]  p1 = 4'b0;
  logic [3:0]  p4 = 4'b0;
  always @(posedge clk) begin
    p1 <= {p1[2:0], a_mem_en};
    p4 <= {p4[2:0], b_mem_en};
  end
  assign a_mem_rdata = p1[0] ? rd1 : 32'hDEAD_0000;
  assign b_mem_rdata = p4[3] ? rd4 : 32'hDEAD_0000;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .MEM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .i_req_valid(i_valid), .i_req_ready(a_i_ready), .i_req_addr(i_addr),
    .i_rsp_valid(a_i_rsp_valid), .i_rsp_data(a_i_rsp_data),
    .d_req_valid(d_valid), .d_req_ready(a_d_ready), .d_req_addr(d_addr),
    .d_req_we(d_we), .d_req_wdata(d_wdata), .d_req_wstrb(d_wstrb),
    .d_rsp_valid(a_d_rsp_valid), .d_rsp_data(a_d_rsp_data),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(12), .MEM_LAT(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .i_req_valid(i4_valid), .i_req_ready(b_i_ready), .i_req_addr(i_addr),
    .i_rsp_valid(b_i_rsp_valid), .i_rsp_data(b_i_rsp_data),
    .d_req_valid(d4_valid), .d_req_ready(b_d_ready), .d_req_addr(d_addr),
    .d_req_we(d_we), .d_req_wdata(d_wdata), .d_req_wstrb(d_wstrb),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are changed right after, checks happen a further #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_quiet(input string tag);
    chk({tag, ".i_ready"}, a_i_ready, 0);
    chk({tag, ".d_ready"}, a_d_ready, 0);
    chk({tag, ".i_rsp_v"}, a_i_rsp_valid, 0);
    chk({tag, ".d_rsp_v"}, a_d_rsp_valid, 0);
    chk({tag, ".mem_en"}, a_mem_en, 0);
    chk({tag, ".mem_we"}, a_mem_we, 0);
    chk({tag, ".busy"}, a_busy, 0);
    chk({tag, ".mem_addr"}, a_mem_addr, 0);
    chk({tag, ".mem_wdata"}, a_mem_wdata, 0);
    chk({tag, ".i_rsp_d"}, a_i_rsp_data, 0);
    chk({tag, ".d_rsp_d"}, a_d_rsp_data, 0);
  endtask

  initial begin
    int         g;
    logic [3:0] order;
    resetn = 1'b0; i_valid = 1'b0; i_addr = 32'h0; d_valid = 1'b0; d4_valid = 1'b0;
    i4_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
    rd1 = 32'h0; rd4 = 32'h0;

    // Reset state, with a request pending: nothing may be granted.
    tick(); tick();
    i_valid = 1'b1; d_valid = 1'b1;
    #1;
    chk_a_quiet("rst");
    chk("rst.b_busy", b_busy, 0);
    tick();
    i_valid = 1'b0; d_valid = 1'b0;

    // Basic fetch, MEM_LAT=1: addr 0x8 -> word 2, data 0x13 at cycle 3.
    resetn = 1'b1; rd1 = 32'h0000_0013; i_valid = 1'b1; i_addr = 32'h0000_0008;
    #1;
    chk("f.c0.i_ready", a_i_ready, 1);
    chk("f.c0.d_ready", a_d_ready, 0);
    chk("f.c0.busy", a_busy, 0);
    tick();
    i_valid = 1'b0; d_valid = 1'b1;   // D asks while busy: must not be granted
    #1;
    chk("f.c1.mem_en", a_mem_en, 1);
    chk("f.c1.mem_addr", a_mem_addr, 2);
    chk("f.c1.mem_we", a_mem_we, 0);
    chk("f.c1.d_ready", a_d_ready, 0);
    chk("f.c1.busy", a_busy, 1);
    tick(); #1;
    chk("f.c2.mem_en", a_mem_en, 0);
    chk("f.c2.i_rsp_v", a_i_rsp_valid, 0);
    tick();
    d_valid = 1'b0;                   // D withdraws before it was ever accepted
    #1;
    chk("f.c3.i_rsp_v", a_i_rsp_valid, 1);
    chk("f.c3.i_rsp_d", a_i_rsp_data, 32'h13);
    chk("f.c3.d_rsp_v", a_d_rsp_valid, 0);
    tick(); #1;
    chk("f.c4.i_rsp_v", a_i_rsp_valid, 0);
    chk("f.c4.i_rsp_hold", a_i_rsp_data, 32'h13);
    chk("f.c4.busy", a_busy, 0);
    tick(); #1;
    chk("wd.busy", a_busy, 0);
    chk("wd.mem_en", a_mem_en, 0);

    // Alternation: both valid continuously from reset -> D, I, D, I.
    resetn = 1'b0;
    tick();
    resetn = 1'b1; i_valid = 1'b1; d_valid = 1'b1; d_addr = 32'h0000_0100; rd1 = 32'h0000_0055;
    g = 0; order = 4'b0;
    for (int k = 0; k < 30 && g < 4; k++) begin
      #1;
      if (a_d_ready && !a_i_ready) begin order[g] = 1'b1; g++; end
      else if (a_i_ready && !a_d_ready) begin order[g] = 1'b0; g++; end
      tick();
    end
    i_valid = 1'b0; d_valid = 1'b0;
    chk("arb.count", g, 4);
    chk("arb.g0", order[0], 1);
    chk("arb.g1", order[1], 0);
    chk("arb.g2", order[2], 1);
    chk("arb.g3", order[3], 0);
    tick(); tick(); tick(); tick();
    #1;
    chk("arb.d_load_d", a_d_rsp_data, 32'h55);

    // Store: addr 0x10 -> word 4, wstrb 0011, ack with data 0.
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #1;
    chk("st.c0.d_ready", a_d_ready, 1);
    tick();
    d_valid = 1'b0;
    #1;
    chk("st.c1.mem_en", a_mem_en, 1);
    chk("st.c1.mem_we", a_mem_we, 4'b0011);
    chk("st.c1.mem_addr", a_mem_addr, 4);
    chk("st.c1.mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick(); #1;
    chk("st.c2.mem_we", a_mem_we, 0);
    chk("st.c2.mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick(); #1;
    chk("st.c3.d_rsp_v", a_d_rsp_valid, 1);
    chk("st.c3.d_rsp_d", a_d_rsp_data, 0);
    chk("st.c3.mem_we", a_mem_we, 0);
    tick();

    // Store with no byte enables: no write, still acked.
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0014; d_wdata = 32'h1111_2222; d_wstrb = 4'b0000;
    #1;
    chk("s0.c0.d_ready", a_d_ready, 1);
    tick();
    d_valid = 1'b0;
    #1;
    chk("s0.c1.mem_en", a_mem_en, 1);
    chk("s0.c1.mem_we", a_mem_we, 0);
    tick(); tick(); #1;
    chk("s0.c3.d_rsp_v", a_d_rsp_valid, 1);
    tick();

    // Inputs scrambled every cycle after acceptance must not reach the transaction.
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    rd1 = 32'h0000_0077;
    #1;
    chk("hold.c0.d_ready", a_d_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      d_valid = 1'b0; d_we = k[0]; d_addr = 32'h0000_0F00 + 32'(k * 4);
      d_wdata = 32'hA5A5_0000 + 32'(k); d_wstrb = 4'(k); i_addr = 32'h0000_0300 + 32'(k);
      #1;
      chk("hold.mem_addr", a_mem_addr, 8);
      chk("hold.mem_wdata", a_mem_wdata, 32'h1234_5678);
      if (k == 1) chk("hold.mem_we", a_mem_we, 0);
      if (k == 3) begin
        chk("hold.d_rsp_v", a_d_rsp_valid, 1);
        chk("hold.d_rsp_d", a_d_rsp_data, 32'h77);
      end
    end
    tick();

    // MEM_LAT=4 load: response 6 cycles after acceptance, busy for 6 cycles.
    d4_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_wstrb = 4'h0; rd4 = 32'h4444_0004;
    #1;
    chk("l4.c0.d_ready", b_d_ready, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      d4_valid = 1'b0;
      #1;
      chk("l4.busy", b_busy, (k <= 6) ? 1 : 0);
      chk("l4.d_rsp_v", b_d_rsp_valid, (k == 6) ? 1 : 0);
      if (k == 1) chk("l4.mem_addr", b_mem_addr, 16);
      if (k == 6) chk("l4.d_rsp_d", b_d_rsp_data, 32'h4444_0004);
    end

    // Reset during WAIT drops the fetch; a new fetch is taken in the first IDLE cycle after.
    i_valid = 1'b1; i_addr = 32'h0000_0020; rd1 = 32'h0000_0099;
    #1;
    chk("rw.c0.i_ready", a_i_ready, 1);
    tick();
    i_valid = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    chk("rw.c2.i_rsp_v", a_i_rsp_valid, 0);
    chk("rw.c2.busy", a_busy, 0);
    tick(); #1;
    chk_a_quiet("rw.c3");
    resetn = 1'b1; i_valid = 1'b1; i_addr = 32'h0000_000C; rd1 = 32'h0000_00AB;
    #1;
    chk("rw.rel.i_ready", a_i_ready, 1);
    tick();
    i_valid = 1'b0;
    #1;
    chk("rw.c4.mem_en", a_mem_en, 1);
    chk("rw.c4.mem_addr", a_mem_addr, 3);
    tick(); tick(); #1;
    chk("rw.c6.i_rsp_v", a_i_rsp_valid, 1);
    chk("rw.c6.i_rsp_d", a_i_rsp_data, 32'hAB);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory word-address width.
REQ-002 SHALL have parameter MEM_LAT, default 1, legal 1..4: cycles from the mem_en cycle to the mem_rdata-valid cycle.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 i_req_valid  in  1  instruction-fetch request.
REQ-006 i_req_ready  out  1  fetch request accepted this cycle.
REQ-007 i_req_addr  in  32  fetch byte address.
REQ-008 i_rsp_valid  out  1  one-cycle fetch response strobe.
REQ-009 i_rsp_data  out  32  fetched word.
REQ-010 d_req_valid  in  1  data request.
REQ-011 d_req_ready  out  1  data request accepted this cycle.
REQ-012 d_req_addr  in  32  data byte address.
REQ-013 d_req_we  in  1  1 = store, 0 = load.
REQ-014 d_req_wdata  in  32  store data.
REQ-015 d_req_wstrb  in  4  store byte enables.
REQ-016 d_rsp_valid  out  1  one-cycle data response or store-ack strobe.
REQ-017 d_rsp_data  out  32  load data; 0 for store acks.
REQ-018 mem_en  out  1  memory access strobe.
REQ-019 mem_we  out  4  byte write enables.
REQ-020 mem_addr  out  ADDR_W  word address.
REQ-021 mem_wdata  out  32  write data.
REQ-022 mem_rdata  in  32  read data.
REQ-023 busy  out  1  high whenever the state is not IDLE.

Function
REQ-024 SHALL implement states IDLE, ACCESS, WAIT, RESP, with at most one transaction outstanding.
REQ-025 In IDLE, a ready output SHALL be driven combinationally high for the selected requester only; ready SHALL be 0 in every other state.
REQ-026 Selection with a single valid requester SHALL pick that requester.
REQ-027 Selection with both requesters valid SHALL pick the requester not granted last; last_grant resets to I, so the first conflict grants D.
REQ-028 Acceptance (valid && ready) SHALL register owner, mem_addr = addr[ADDR_W+1:2] (addr[1:0] ignored), mem_wdata and write intent, update last_grant, and move to ACCESS.
REQ-029 ACCESS SHALL last 1 cycle with mem_en = 1, mem_we = (owner D && we) ? wstrb : 4'b0, then go to WAIT.
REQ-030 WAIT SHALL last MEM_LAT cycles (counter, mem_en = 0); mem_rdata SHALL be captured on the last WAIT cycle, then go to RESP.
REQ-031 Fetch/load latency, acceptance cycle n: mem_en at n+1, rdata captured at n+1+MEM_LAT, rsp_valid at n+2+MEM_LAT, next acceptance possible at n+3+MEM_LAT.
REQ-032 Stores SHALL follow the same timing; d_rsp_valid pulses and d_rsp_data = 0.
REQ-033 A store with wstrb = 0 SHALL still complete with mem_we = 0 and be acked.
REQ-034 RESP SHALL last 1 cycle, pulse only the owner's rsp_valid, and return to IDLE.
REQ-035 rsp_data SHALL hold its last value while rsp_valid = 0.
REQ-036 A request input changing after acceptance SHALL not affect the transaction in flight.
REQ-037 A requester withdrawing valid before acceptance SHALL be permitted, with no transaction started.
REQ-038 mem_addr, mem_wdata SHALL be stable from ACCESS through RESP.

Reset
REQ-039 resetn = 0 at a clock edge SHALL force state IDLE, last_grant = I, counter = 0.
REQ-040 During reset, all ready, rsp_valid, mem_en, mem_we and busy SHALL be 0, rsp_data/mem_addr/mem_wdata SHALL be 0, and ready SHALL be low while resetn = 0.
REQ-041 Reset mid-transaction SHALL drop the transaction with no rsp_valid, and memory writes not yet strobed SHALL not occur.

Verification
REQ-042 MEM_LAT=1, i_req_valid with addr 0x0000_0008 at cycle 0, mem_rdata = 0x0000_0013 -> i_req_ready cycle 0, mem_en and mem_addr = 2 at cycle 1, i_rsp_valid with i_rsp_data = 0x13 at cycle 3.
REQ-043 Both valid continuously from reset, for 4 grants -> grant order D, I, D, I.
REQ-044 Store, addr 0x10, wdata 0xDEADBEEF, wstrb 4'b0011 -> mem_we = 4'b0011 for exactly 1 cycle, mem_addr = 4, d_rsp_valid with d_rsp_data = 0.
REQ-045 MEM_LAT=4 load -> d_rsp_valid exactly 6 cycles after acceptance, and busy high for 6 cycles.
REQ-046 resetn low during WAIT -> no rsp_valid, all outputs 0 next cycle, a new request accepted in the first IDLE cycle after release.
REQ-047 Request inputs changed every cycle after acceptance -> mem_addr, mem_wdata and response unchanged.
